// File: rtl/aximm_d128_user_resp_mem.sv
// aximm_d128_user_resp_mem
// 128-bit AXI4 responder backed by a word-addressed memory. The read and write paths
// are independent, and each path has one outstanding burst.
// Optional build macro: RESP_MEM_BP_EN adds LFSR-driven backpressure on the ready outputs.
module aximm_d128_user_resp_mem #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter logic [15:0] BP_SEED    = 16'hACE1
) (
    input  logic         clk_wr,
    input  logic         rst_wr,
    input  logic [3:0]   user_arid,
    input  logic [2:0]   user_arsize,
    input  logic [7:0]   user_arlen,
    input  logic [1:0]   user_arburst,
    input  logic [31:0]  user_araddr,
    input  logic         user_arvalid,
    output logic         user_arready,
    input  logic [3:0]   user_awid,
    input  logic [2:0]   user_awsize,
    input  logic [7:0]   user_awlen,
    input  logic [1:0]   user_awburst,
    input  logic [31:0]  user_awaddr,
    input  logic         user_awvalid,
    output logic         user_awready,
    input  logic [3:0]   user_wid,
    input  logic [127:0] user_wdata,
    input  logic [15:0]  user_wstrb,
    input  logic         user_wlast,
    input  logic         user_wvalid,
    output logic         user_wready,
    output logic [3:0]   user_rid,
    output logic [127:0] user_rdata,
    output logic         user_rlast,
    output logic [1:0]   user_rresp,
    output logic         user_rvalid,
    input  logic         user_rready,
    output logic [3:0]   user_bid,
    output logic [1:0]   user_bresp,
    output logic         user_bvalid,
    input  logic         user_bready
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    function automatic logic out_of_range(input logic [31:0] addr);
        return |(addr >> (DEPTH_LOG2 + 4));
    endfunction

    function automatic logic [DEPTH_LOG2-1:0] word_index(input logic [31:0] addr);
        return addr[DEPTH_LOG2+3:4];
    endfunction

    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

    // Bursts that are malformed as a whole (oversized beats, reserved or bad WRAP)
    function automatic logic burst_error(input logic [2:0] size, input logic [7:0] len,
                                         input logic [1:0] burst);
        return (size > 3'd4) || (burst == 2'b11) || ((burst == 2'b10) && !wrap_len_ok(len));
    endfunction

    // Malformed WRAP and the reserved encoding are walked as INCR
    function automatic logic [1:0] eff_burst(input logic [7:0] len, input logic [1:0] burst);
        if ((burst == 2'b11) || ((burst == 2'b10) && !wrap_len_ok(len))) return 2'b01;
        return burst;
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [2:0] size,
                                              input logic [7:0] len, input logic [1:0] burst);
        logic [31:0] step, incr, mask;
        step = 32'd1 << size;
        incr = (addr & ~(step - 32'd1)) + step;
        mask = (({24'd0, len} + 32'd1) << size) - 32'd1;
        case (burst)
            2'b00:   return addr;
            2'b10:   return (addr & ~mask) | (incr & mask);
            default: return incr;
        endcase
    endfunction

    logic [127:0] mem [DEPTH];

    logic                  rst_done_q;
    logic                  rdy_en;

    logic [1:0]            w_state_q;
    logic [3:0]            w_id_q;
    logic [31:0]           w_addr_q;
    logic [7:0]            w_len_q;
    logic [2:0]            w_size_q;
    logic [1:0]            w_burst_q;
    logic [7:0]            w_cnt_q;
    logic                  w_err_q;

    logic [0:0]            r_state_q;
    logic [3:0]            r_id_q;
    logic [31:0]           r_addr_q;
    logic [7:0]            r_len_q;
    logic [2:0]            r_size_q;
    logic [1:0]            r_burst_q;
    logic [7:0]            r_cnt_q;
    logic                  r_err_q;
    logic                  r_oor_q;
    logic [127:0]          r_data_q;

    logic                  aw_fire, w_fire, b_fire, ar_fire, r_fire;
    logic                  w_oor, w_last_beat;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic [31:0]           rd_addr;
    logic                  rd_oor;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic                  unused_cfg;

    assign unused_cfg = ^{user_wid, BP_SEED};

    // Readies stay low until the first edge after reset is released
    always_ff @(posedge clk_wr or posedge rst_wr) begin
        if (rst_wr) rst_done_q <= 1'b0;
        else        rst_done_q <= 1'b1;
    end

`ifdef RESP_MEM_BP_EN
    logic [15:0] lfsr_q;

    // Fibonacci LFSR, taps 16,14,13,11; bit 0 stalls all readies for the cycle
    always_ff @(posedge clk_wr or posedge rst_wr) begin
        if (rst_wr) lfsr_q <= BP_SEED;
        else        lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    assign rdy_en = rst_done_q & ~lfsr_q[0];
`else
    assign rdy_en = rst_done_q;
`endif

    assign user_awready = rdy_en & (w_state_q == W_IDLE);
    assign user_wready  = rdy_en & (w_state_q == W_DATA);
    assign user_bvalid  = (w_state_q == W_RESP);
    assign user_bid     = user_bvalid ? w_id_q : 4'd0;
    assign user_bresp   = (user_bvalid && w_err_q) ? 2'b10 : 2'b00;

    assign user_arready = rdy_en & (r_state_q == R_IDLE);
    assign user_rvalid  = (r_state_q == R_DATA);
    assign user_rid     = user_rvalid ? r_id_q : 4'd0;
    assign user_rdata   = r_data_q;
    assign user_rlast   = user_rvalid && (r_cnt_q == r_len_q);
    assign user_rresp   = (user_rvalid && (r_err_q || r_oor_q)) ? 2'b10 : 2'b00;

    assign aw_fire     = user_awvalid & user_awready;
    assign w_fire      = user_wvalid & user_wready;
    assign b_fire      = user_bvalid & user_bready;
    assign ar_fire     = user_arvalid & user_arready;
    assign r_fire      = user_rvalid & user_rready;
    assign w_oor       = out_of_range(w_addr_q);
    assign w_idx       = word_index(w_addr_q);
    assign w_last_beat = (w_cnt_q == w_len_q);

    // Word fetched into r_data_q: the start address on AR, else the following beat
    assign rd_addr = (r_state_q == R_IDLE) ? user_araddr
                                           : next_addr(r_addr_q, r_size_q, r_len_q, r_burst_q);
    assign rd_oor  = out_of_range(rd_addr);
    assign rd_idx  = word_index(rd_addr);

    // Write FSM: capture AW, absorb len+1 beats, then hold B until accepted
    always_ff @(posedge clk_wr or posedge rst_wr) begin
        if (rst_wr) begin
            w_state_q <= W_IDLE;
            w_id_q    <= 4'd0;
            w_addr_q  <= 32'd0;
            w_len_q   <= 8'd0;
            w_size_q  <= 3'd0;
            w_burst_q <= 2'b00;
            w_cnt_q   <= 8'd0;
            w_err_q   <= 1'b0;
        end else begin
            case (w_state_q)
                W_IDLE: if (aw_fire) begin
                    w_id_q    <= user_awid;
                    w_addr_q  <= user_awaddr;
                    w_len_q   <= user_awlen;
                    w_size_q  <= user_awsize;
                    w_burst_q <= eff_burst(user_awlen, user_awburst);
                    w_err_q   <= burst_error(user_awsize, user_awlen, user_awburst);
                    w_cnt_q   <= 8'd0;
                    w_state_q <= W_DATA;
                end
                W_DATA: if (w_fire) begin
                    // Beat count, not wlast, ends the burst; a disagreeing wlast is an error
                    if ((user_wlast != w_last_beat) || w_oor) w_err_q <= 1'b1;
                    w_addr_q <= next_addr(w_addr_q, w_size_q, w_len_q, w_burst_q);
                    if (w_last_beat) w_state_q <= W_RESP;
                    else             w_cnt_q   <= w_cnt_q + 8'd1;
                end
                W_RESP: if (b_fire) w_state_q <= W_IDLE;
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    // Byte-enabled memory write; out-of-range beats are dropped
    always_ff @(posedge clk_wr) begin
        if (w_fire && !w_oor) begin
            for (int b = 0; b < 16; b++) begin
                if (user_wstrb[b]) mem[w_idx][8*b +: 8] <= user_wdata[8*b +: 8];
            end
        end
    end

    // Read FSM: registered fetch on AR and after every accepted beat but the last
    always_ff @(posedge clk_wr or posedge rst_wr) begin
        if (rst_wr) begin
            r_state_q <= R_IDLE;
            r_id_q    <= 4'd0;
            r_addr_q  <= 32'd0;
            r_len_q   <= 8'd0;
            r_size_q  <= 3'd0;
            r_burst_q <= 2'b00;
            r_cnt_q   <= 8'd0;
            r_err_q   <= 1'b0;
            r_oor_q   <= 1'b0;
            r_data_q  <= 128'd0;
        end else begin
            case (r_state_q)
                R_IDLE: if (ar_fire) begin
                    r_id_q    <= user_arid;
                    r_addr_q  <= user_araddr;
                    r_len_q   <= user_arlen;
                    r_size_q  <= user_arsize;
                    r_burst_q <= eff_burst(user_arlen, user_arburst);
                    r_err_q   <= burst_error(user_arsize, user_arlen, user_arburst);
                    r_cnt_q   <= 8'd0;
                    r_oor_q   <= rd_oor;
                    r_data_q  <= rd_oor ? 128'd0 : mem[rd_idx];
                    r_state_q <= R_DATA;
                end
                R_DATA: if (r_fire) begin
                    if (r_cnt_q == r_len_q) begin
                        r_state_q <= R_IDLE;
                    end else begin
                        r_cnt_q  <= r_cnt_q + 8'd1;
                        r_addr_q <= rd_addr;
                        r_oor_q  <= rd_oor;
                        r_data_q <= rd_oor ? 128'd0 : mem[rd_idx];
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aximm_d128_user_resp_mem.sv
// Bench for aximm_d128_user_resp_mem: table of directed bursts, hand-written corner
// sequences and randomized write/read-back pairs against a byte-level memory model.
module tb_aximm_d128_user_resp_mem;

    localparam int WORDS  = 1024;
    localparam int BUDGET = 200;

    logic         clk_wr = 1'b0;
    logic         rst_wr = 1'b1;
    logic [3:0]   user_arid = '0, user_awid = '0, user_wid = '0;
    logic [2:0]   user_arsize = '0, user_awsize = '0;
    logic [7:0]   user_arlen = '0, user_awlen = '0;
    logic [1:0]   user_arburst = '0, user_awburst = '0;
    logic [31:0]  user_araddr = '0, user_awaddr = '0;
    logic         user_arvalid = 1'b0, user_awvalid = 1'b0, user_wvalid = 1'b0;
    logic         user_wlast = 1'b0, user_rready = 1'b0, user_bready = 1'b0;
    logic [127:0] user_wdata = '0;
    logic [15:0]  user_wstrb = '0;
    logic         user_arready, user_awready, user_wready, user_rlast, user_rvalid, user_bvalid;
    logic [3:0]   user_rid, user_bid;
    logic [127:0] user_rdata;
    logic [1:0]   user_rresp, user_bresp;

    aximm_d128_user_resp_mem dut (
        .clk_wr(clk_wr), .rst_wr(rst_wr),
        .user_arid(user_arid), .user_arsize(user_arsize), .user_arlen(user_arlen),
        .user_arburst(user_arburst), .user_araddr(user_araddr),
        .user_arvalid(user_arvalid), .user_arready(user_arready),
        .user_awid(user_awid), .user_awsize(user_awsize), .user_awlen(user_awlen),
        .user_awburst(user_awburst), .user_awaddr(user_awaddr),
        .user_awvalid(user_awvalid), .user_awready(user_awready),
        .user_wid(user_wid), .user_wdata(user_wdata), .user_wstrb(user_wstrb),
        .user_wlast(user_wlast), .user_wvalid(user_wvalid), .user_wready(user_wready),
        .user_rid(user_rid), .user_rdata(user_rdata), .user_rlast(user_rlast),
        .user_rresp(user_rresp), .user_rvalid(user_rvalid), .user_rready(user_rready),
        .user_bid(user_bid), .user_bresp(user_bresp), .user_bvalid(user_bvalid),
        .user_bready(user_bready)
    );

    always #5 clk_wr = ~clk_wr;

    int           vectors = 0;
    int           miscompares = 0;
    logic [127:0] ref_mem [WORDS];
    logic [127:0] wbeat_data [16];
    logic [15:0]  wbeat_strb [16];

    typedef struct {
        bit          is_wr;
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [1:0]  exp_resp;  // bresp for writes, first-beat rresp for reads
    } vec_t;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: no handshake within %0d cycles (t=%0t)", name, BUDGET, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_burst_err(input logic [7:0] len, input logic [2:0] size,
                                       input logic [1:0] burst);
        return (size > 3'd4) || (burst == 2'b11) ||
               ((burst == 2'b10) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
    endfunction

    function automatic logic [31:0] m_beat_addr(input logic [31:0] start, input logic [7:0] len,
                                                input logic [2:0] size, input logic [1:0] burst,
                                                input int i);
        logic [31:0] bytes, aligned, blk, base;
        logic [1:0]  b;
        b = burst;
        if (burst == 2'b11 || (burst == 2'b10 && !(len inside {8'd1, 8'd3, 8'd7, 8'd15})))
            b = 2'b01;
        bytes   = 32'd1 << size;
        aligned = start - (start % bytes);
        if (i == 0 || b == 2'b00) return start;
        if (b == 2'b01) return aligned + 32'(i) * bytes;
        blk  = (32'(len) + 32'd1) * bytes;
        base = start - (start % blk);
        return base + ((aligned - base + 32'(i) * bytes) % blk);
    endfunction

    function automatic bit m_oor(input logic [31:0] a);
        return a >= 32'(WORDS * 16);
    endfunction

    // Applies the staged beats to the model; returns the expected bresp
    function automatic logic [1:0] m_write(input logic [31:0] addr, input logic [7:0] len,
                                           input logic [2:0] size, input logic [1:0] burst,
                                           input int bad_beat, input int nbeats);
        bit err;
        logic [31:0] a;
        err = m_burst_err(len, size, burst) || (bad_beat >= 0);
        for (int i = 0; i < nbeats; i++) begin
            a = m_beat_addr(addr, len, size, burst, i);
            if (m_oor(a)) begin
                err = 1'b1;
            end else begin
                for (int b = 0; b < 16; b++)
                    if (wbeat_strb[i][b]) ref_mem[a >> 4][8*b +: 8] = wbeat_data[i][8*b +: 8];
            end
        end
        return err ? 2'b10 : 2'b00;
    endfunction

    // ---------------- bus drivers ----------------
    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input int bad_beat,
                             input bit gaps, input bit timing, input logic [1:0] exp_bresp);
        int n;
        @(negedge clk_wr);
        user_awid = id; user_awaddr = addr; user_awlen = len;
        user_awsize = size; user_awburst = burst; user_awvalid = 1'b1;
        n = 0;
        while (!user_awready && n < BUDGET) begin @(negedge clk_wr); n++; end
        if (n >= BUDGET) begin timeout("aw_handshake"); user_awvalid = 1'b0; return; end
        @(negedge clk_wr);
        user_awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk_wr);
            user_wdata = wbeat_data[i]; user_wstrb = wbeat_strb[i];
            user_wlast = (i == int'(len)) ^ (i == bad_beat);
            user_wvalid = 1'b1;
            n = 0;
            while (!user_wready && n < BUDGET) begin @(negedge clk_wr); n++; end
            if (n >= BUDGET) begin timeout("w_handshake"); user_wvalid = 1'b0; return; end
            if (timing) check("wready_latency", 128'(n), 128'd0);
            @(negedge clk_wr);
            user_wvalid = 1'b0;
        end
        if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk_wr);
        user_bready = 1'b1;
        n = 0;
        while (!user_bvalid && n < BUDGET) begin @(negedge clk_wr); n++; end
        if (n >= BUDGET) begin timeout("b_handshake"); user_bready = 1'b0; return; end
        if (timing) check("bvalid_latency", 128'(n), 128'd0);
        check("bresp", 128'(user_bresp), 128'(exp_bresp));
        check("bid", 128'(user_bid), 128'(id));
        @(negedge clk_wr);
        user_bready = 1'b0;
        if (timing) check("awready_after_b", 128'(user_awready), 128'd1);
    endtask

    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int stall_beat,
                            input int stall_cyc, input bit gaps, input bit timing,
                            input int tbl_resp);
        int n;
        logic [31:0]  a;
        logic [127:0] exp_d;
        logic [1:0]   exp_r;
        @(negedge clk_wr);
        user_arid = id; user_araddr = addr; user_arlen = len;
        user_arsize = size; user_arburst = burst; user_arvalid = 1'b1;
        n = 0;
        while (!user_arready && n < BUDGET) begin @(negedge clk_wr); n++; end
        if (n >= BUDGET) begin timeout("ar_handshake"); user_arvalid = 1'b0; return; end
        @(negedge clk_wr);
        user_arvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            a     = m_beat_addr(addr, len, size, burst, i);
            exp_d = m_oor(a) ? 128'd0 : ref_mem[a >> 4];
            exp_r = (m_burst_err(len, size, burst) || m_oor(a)) ? 2'b10 : 2'b00;
            if (i == stall_beat) begin
                user_rready = 1'b0;
                repeat (stall_cyc) begin
                    check("stall_rvalid", 128'(user_rvalid), 128'd1);
                    check("stall_rdata", user_rdata, exp_d);
                    check("stall_rid", 128'(user_rid), 128'(id));
                    @(negedge clk_wr);
                end
            end
            if (gaps) begin
                user_rready = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk_wr);
            end
            user_rready = 1'b1;
            n = 0;
            while (!user_rvalid && n < BUDGET) begin @(negedge clk_wr); n++; end
            if (n >= BUDGET) begin timeout("r_handshake"); user_rready = 1'b0; return; end
            if (timing) check("rvalid_latency", 128'(n), 128'd0);
            check("rdata", user_rdata, exp_d);
            check("rresp", 128'(user_rresp), 128'(exp_r));
            check("rlast", 128'(user_rlast), 128'(i == int'(len)));
            check("rid", 128'(user_rid), 128'(id));
            if (i == 0 && tbl_resp >= 0) check("table_rresp", 128'(user_rresp), 128'(tbl_resp));
            @(negedge clk_wr);
        end
        user_rready = 1'b0;
        if (timing) begin
            check("rvalid_after_last", 128'(user_rvalid), 128'd0);
            check("arready_after_r", 128'(user_arready), 128'd1);
        end
    endtask

    task automatic stage_beats(input bit rand_strb);
        for (int i = 0; i < 16; i++) begin
            wbeat_data[i] = {$urandom, $urandom, $urandom, $urandom};
            wbeat_strb[i] = rand_strb ? 16'($urandom) : 16'hFFFF;
        end
    endtask

    function automatic vec_t mk(input bit w, input logic [3:0] id, input logic [31:0] addr,
                                input logic [7:0] len, input logic [2:0] size,
                                input logic [1:0] burst, input logic [1:0] resp);
        vec_t v;
        v.is_wr = w; v.id = id; v.addr = addr; v.len = len;
        v.size = size; v.burst = burst; v.exp_resp = resp;
        return v;
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [$];
        logic [1:0]  eb;
        logic [127:0] old_word, new_word;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [3:0]  id;
        int          bad, n;

        // Directed bursts and their expected response codes
        tbl.push_back(mk(1, 4'd1,  32'h0000_0100, 8'd3, 3'd4, 2'b01, 2'b00)); // INCR write
        tbl.push_back(mk(0, 4'd2,  32'h0000_0100, 8'd3, 3'd4, 2'b01, 2'b00));
        tbl.push_back(mk(1, 4'd3,  32'h0000_0130, 8'd3, 3'd4, 2'b10, 2'b00)); // WRAP
        tbl.push_back(mk(0, 4'd4,  32'h0000_0100, 8'd3, 3'd4, 2'b01, 2'b00));
        tbl.push_back(mk(1, 4'd5,  32'h0000_0000, 8'd2, 3'd4, 2'b10, 2'b10)); // bad WRAP len
        tbl.push_back(mk(0, 4'd6,  32'h0000_0000, 8'd3, 3'd4, 2'b01, 2'b00));
        tbl.push_back(mk(1, 4'd7,  32'h0000_0040, 8'd1, 3'd5, 2'b01, 2'b10)); // size 5
        tbl.push_back(mk(1, 4'd8,  32'h0000_0080, 8'd1, 3'd4, 2'b11, 2'b10)); // reserved burst
        tbl.push_back(mk(0, 4'd9,  32'h0010_0000, 8'd3, 3'd4, 2'b01, 2'b10)); // out of range
        tbl.push_back(mk(1, 4'd10, 32'h0010_0000, 8'd1, 3'd4, 2'b01, 2'b10));
        tbl.push_back(mk(0, 4'd11, 32'h0000_3FF0, 8'd1, 3'd4, 2'b01, 2'b00)); // runs off end
        tbl.push_back(mk(1, 4'd12, 32'h0000_0300, 8'd2, 3'd4, 2'b00, 2'b00)); // FIXED
        tbl.push_back(mk(0, 4'd13, 32'h0000_0300, 8'd2, 3'd4, 2'b00, 2'b00));
        tbl.push_back(mk(0, 4'd14, 32'h0000_0040, 8'd3, 3'd4, 2'b01, 2'b00));
        tbl.push_back(mk(1, 4'd15, 32'h0000_0105, 8'd3, 3'd2, 2'b01, 2'b00)); // narrow unaligned
        tbl.push_back(mk(0, 4'd0,  32'h0000_0100, 8'd1, 3'd4, 2'b01, 2'b00));
        tbl.push_back(mk(0, 4'd3,  32'h0000_0000, 8'd0, 3'd5, 2'b01, 2'b10)); // size 5 read

        // Reset state
        repeat (3) @(negedge clk_wr);
        check("rst_awready", 128'(user_awready), 128'd0);
        check("rst_arready", 128'(user_arready), 128'd0);
        check("rst_wready", 128'(user_wready), 128'd0);
        check("rst_valids", 128'({user_rvalid, user_bvalid, user_rlast}), 128'd0);
        check("rst_payload", {user_rdata[119:0], user_rid, user_bid}, 128'd0);
        check("rst_resps", 128'({user_rresp, user_bresp}), 128'd0);
        rst_wr = 1'b0;
        check("awready_at_release", 128'(user_awready), 128'd0);
        @(negedge clk_wr);
        check("awready_after_release", 128'(user_awready), 128'd1);
        check("arready_after_release", 128'(user_arready), 128'd1);

        // Fill the whole memory so every later read has a defined expectation
        for (int k = 0; k < WORDS / 16; k++) begin
            stage_beats(1'b0);
            eb = m_write(32'(k * 256), 8'd15, 3'd4, 2'b01, -1, 16);
            axi_write(4'(k), 32'(k * 256), 8'd15, 3'd4, 2'b01, -1, 1'b0, 1'b0, eb);
        end

        // Table of directed bursts
        foreach (tbl[v]) begin
            if (tbl[v].is_wr) begin
                stage_beats(1'b0);
                eb = m_write(tbl[v].addr, tbl[v].len, tbl[v].size, tbl[v].burst, -1,
                             int'(tbl[v].len) + 1);
                axi_write(tbl[v].id, tbl[v].addr, tbl[v].len, tbl[v].size, tbl[v].burst, -1,
                          1'b0, 1'b1, tbl[v].exp_resp);
            end else begin
                axi_read(tbl[v].id, tbl[v].addr, tbl[v].len, tbl[v].size, tbl[v].burst, -1, 0,
                         1'b0, 1'b1, int'(tbl[v].exp_resp));
            end
        end

        // Partial strobes: all-ones word, then zero bytes 4..7
        stage_beats(1'b0);
        wbeat_data[0] = {128{1'b1}};
        eb = m_write(32'h200, 8'd0, 3'd4, 2'b01, -1, 1);
        axi_write(4'd1, 32'h200, 8'd0, 3'd4, 2'b01, -1, 1'b0, 1'b1, 2'b00);
        wbeat_data[0] = 128'd0;
        wbeat_strb[0] = 16'h00F0;
        eb = m_write(32'h200, 8'd0, 3'd4, 2'b01, -1, 1);
        axi_write(4'd2, 32'h200, 8'd0, 3'd4, 2'b01, -1, 1'b0, 1'b1, 2'b00);
        axi_read(4'd3, 32'h200, 8'd0, 3'd4, 2'b01, -1, 0, 1'b0, 1'b1, 0);

        // Early wlast on beat 1 of a len=3 burst, and wlast missing on the final beat
        stage_beats(1'b0);
        eb = m_write(32'h800, 8'd3, 3'd4, 2'b01, 1, 4);
        axi_write(4'd4, 32'h800, 8'd3, 3'd4, 2'b01, 1, 1'b0, 1'b1, 2'b10);
        stage_beats(1'b0);
        eb = m_write(32'h900, 8'd2, 3'd4, 2'b01, 2, 3);
        axi_write(4'd5, 32'h900, 8'd2, 3'd4, 2'b01, 2, 1'b0, 1'b1, 2'b10);
        axi_read(4'd6, 32'h800, 8'd3, 3'd4, 2'b01, -1, 0, 1'b0, 1'b1, 0);

        // Read backpressure: rready low for 5 cycles on beat 2
        axi_read(4'd7, 32'h100, 8'd3, 3'd4, 2'b01, 2, 5, 1'b0, 1'b0, 0);

        // Same-cycle read and write of one word: the read sees the old contents
        old_word = ref_mem[32'h700 >> 4];
        new_word = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk_wr);
        user_awid = 4'd9; user_awaddr = 32'h700; user_awlen = 8'd0;
        user_awsize = 3'd4; user_awburst = 2'b01; user_awvalid = 1'b1;
        @(negedge clk_wr);
        user_awvalid = 1'b0;
        user_wdata = new_word; user_wstrb = 16'hFFFF; user_wlast = 1'b1; user_wvalid = 1'b1;
        user_arid = 4'd10; user_araddr = 32'h700; user_arlen = 8'd0;
        user_arsize = 3'd4; user_arburst = 2'b01; user_arvalid = 1'b1;
        check("collide_wready", 128'(user_wready), 128'd1);
        check("collide_arready", 128'(user_arready), 128'd1);
        @(negedge clk_wr);
        user_wvalid = 1'b0; user_arvalid = 1'b0;
        check("collide_rvalid", 128'(user_rvalid), 128'd1);
        check("collide_rdata_old", user_rdata, old_word);
        check("collide_bvalid", 128'(user_bvalid), 128'd1);
        user_rready = 1'b1; user_bready = 1'b1;
        @(negedge clk_wr);
        user_rready = 1'b0; user_bready = 1'b0;
        ref_mem[32'h700 >> 4] = new_word;
        axi_read(4'd11, 32'h700, 8'd0, 3'd4, 2'b01, -1, 0, 1'b0, 1'b1, 0);

        // Reset in the middle of a write burst
        stage_beats(1'b0);
        @(negedge clk_wr);
        user_awid = 4'd12; user_awaddr = 32'h500; user_awlen = 8'd3;
        user_awsize = 3'd4; user_awburst = 2'b01; user_awvalid = 1'b1;
        n = 0;
        while (!user_awready && n < BUDGET) begin @(negedge clk_wr); n++; end
        @(negedge clk_wr);
        user_awvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            user_wdata = wbeat_data[i]; user_wstrb = 16'hFFFF;
            user_wlast = 1'b0; user_wvalid = 1'b1;
            n = 0;
            while (!user_wready && n < BUDGET) begin @(negedge clk_wr); n++; end
            if (n >= BUDGET) timeout("rst_burst_w");
            if (i < 2) @(negedge clk_wr);
        end
        rst_wr = 1'b1;
        #1;
        check("midrst_readies", 128'({user_awready, user_wready, user_arready}), 128'd0);
        check("midrst_valids", 128'({user_bvalid, user_rvalid, user_rlast}), 128'd0);
        check("midrst_payload", {user_rdata[119:0], user_rid, user_bid}, 128'd0);
        @(posedge clk_wr);
        #1;
        check("midrst_edge", 128'({user_wready, user_bvalid, user_bresp}), 128'd0);
        @(negedge clk_wr);
        user_wvalid = 1'b0;
        rst_wr = 1'b0;
        @(negedge clk_wr);
        check("midrst_awready", 128'(user_awready), 128'd1);
        eb = m_write(32'h500, 8'd3, 3'd4, 2'b01, -1, 2);  // beats 0 and 1 landed
        stage_beats(1'b0);
        eb = m_write(32'h600, 8'd3, 3'd4, 2'b01, -1, 4);
        axi_write(4'd13, 32'h600, 8'd3, 3'd4, 2'b01, -1, 1'b0, 1'b1, 2'b00);
        axi_read(4'd14, 32'h500, 8'd3, 3'd4, 2'b01, -1, 0, 1'b0, 1'b1, 0);
        axi_read(4'd15, 32'h600, 8'd3, 3'd4, 2'b01, -1, 0, 1'b0, 1'b1, 0);

        // Randomized write/read-back pairs with handshake gaps
        for (int t = 0; t < 40; t++) begin
            id    = 4'($urandom);
            size  = 3'($urandom_range(0, 4));
            burst = 2'($urandom_range(0, 2));
            if (burst == 2'b10) begin
                n   = $urandom_range(0, 2);
                len = (n == 0) ? 8'd1 : (n == 1) ? 8'd3 : 8'd7;
            end else begin
                len = 8'($urandom_range(0, 7));
            end
            addr = 32'($urandom_range(0, 32'h3FFF));
            addr = addr & ~((32'd1 << size) - 32'd1);
            if ($urandom_range(0, 9) == 0) addr = addr | 32'h0001_0000;
            bad = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, int'(len))) : -1;
            stage_beats(1'b1);
            eb = m_write(addr, len, size, burst, bad, int'(len) + 1);
            axi_write(id, addr, len, size, burst, bad, 1'b1, 1'b0, eb);
            axi_read(~id, addr, len, size, burst, int'($urandom_range(0, int'(len))),
                     int'($urandom_range(0, 3)), 1'b1, 1'b0, -1);
        end

        repeat (2) @(negedge clk_wr);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/aximm_d128_user_resp_mem.md
# aximm_d128_user_resp_mem

AXI4 memory-mapped responder (subordinate) model with 128-bit data that terminates the follower-side user AXI-MM interface of the d128 half-to-half link. It accepts AR/AW/W traffic emitted by the follower bridge and returns R/B responses from an internal word-addressed memory. The AXI-MM master that issues requests into the leader side therefore gets completed transactions end to end. Read and write paths run independently, with one outstanding burst per direction.

## Interface
- DEPTH_LOG2, 10: memory holds 2^DEPTH_LOG2 words of 128 bits; word index = addr[DEPTH_LOG2+3:4].
- BP_SEED, 16'hACE1: initial LFSR value, used only with RESP_MEM_BP_EN.
- clk_wr  in  1  clock for all logic.
- rst_wr  in  1  asynchronous, active-high reset.
- user_arid/arsize/arlen/arburst/araddr  in  4/3/8/2/32  read address fields.
- user_arvalid  in  1; user_arready  out  1.
- user_awid/awsize/awlen/awburst/awaddr  in  4/3/8/2/32  write address fields.
- user_awvalid  in  1; user_awready  out  1.
- user_wid/wdata/wstrb/wlast  in  4/128/16/1  write data; wid is ignored.
- user_wvalid  in  1; user_wready  out  1.
- user_rid/rdata/rlast/rresp  out  4/128/1/2  read data.
- user_rvalid  out  1; user_rready  in  1.
- user_bid/bresp  out  4/2  write response.
- user_bvalid  out  1; user_bready  in  1.

## Operation
- Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: awready=1. On the AW handshake, capture id, addr, len, size and burst, clear the error flag, and go to W_DATA.
  - W_DATA: wready=1. Each W handshake writes the bytes of wdata whose wstrb bit is set to mem[word index], then advances the address.
  - Leave W_DATA on the beat where the beat counter equals len, regardless of wlast.
- Write errors:
  - A wlast mismatch on any beat sets the error flag: wlast=1 before the final beat, or wlast=0 on the final beat.
  - An out-of-range beat (addr[31:DEPTH_LOG2+4] != 0) sets the error flag and is not written.
  - W_RESP: bvalid=1, bid=captured awid, bresp=2'b10 if the error flag is set, otherwise 2'b00. Return to W_IDLE on the B handshake.
- Read FSM: R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: arready=1. On the AR handshake, capture the fields and go to R_DATA.
  - R_DATA: rvalid=1. rid=captured arid; rdata=registered read of the current word index; rlast=1 on beat len.
  - rresp=2'b10 with rdata=0 for out-of-range beats, otherwise 2'b00.
  - A beat completes on the R handshake. The address and rdata advance the cycle after the handshake. Return to R_IDLE after the rlast handshake.
- Address update per beat:
  - FIXED (2'b00): address unchanged.
  - INCR (2'b01): addr += 1<<size.
  - WRAP (2'b10): addr += 1<<size, then wrap within the block of (len+1)<<size bytes aligned to that size.
  - WRAP is legal only for len ∈ {1,3,7,15}. Any other len under WRAP, and burst=2'b11, are treated as INCR and flag the whole burst SLVERR.
- The first beat uses the unaligned start address as given. Subsequent beats are aligned to size.
- size > 3'd4 flags SLVERR for the whole burst; the memory is still indexed by word.
- Same-cycle read and write to the same word: the read returns the old data, and the write lands.

## Timing
- Reset values: all ready, valid, rlast, id, resp and data outputs are 0. Both FSMs are in IDLE and the beat counters are 0. Memory contents are not reset.
- The ready outputs are registered-state decodes. awready and arready rise the first cycle after reset deasserts.
- Read latency: AR handshake at cycle N gives the first rvalid at N+1. With rready held at 1, one beat is returned per cycle, so a len=L burst ends at N+1+L.
- Write: AW handshake at N gives wready at N+1. With wvalid held at 1, the final beat is at N+1+len and bvalid is at N+2+len.
- Back-to-back: the next AW or AR can be accepted one cycle after the B or last R handshake. The response and the next request do not overlap.
- Valid/payload stability: once rvalid or bvalid is asserted, it and its payload hold until the handshake.
- Asserting rst_wr mid-burst aborts both FSMs immediately. Partially written data stays in memory, and no response is emitted for the aborted burst.

## Configuration
- RESP_MEM_BP_EN defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11, loaded with BP_SEED at reset) advances every cycle. Bit 0 = 1 forces awready, wready and arready low that cycle, overriding the FSM decode. Valid outputs are never gated.
- RESP_MEM_BP_EN undefined: no LFSR is present, and readies follow the FSM decode exactly. This is the default for link-throughput runs.

## Test plan
- INCR write then read: AW addr=0x100, len=3, size=4, wstrb=16'hFFFF, data 0..3. Expect bresp=0 and bid=awid. AR to the same address returns data 0..3 with rlast on beat 3 and rresp=0.
- Partial strobes: write 0xFF..FF to 0x200, then write 0 with wstrb=16'h00F0. A read of 0x200 returns a word whose bytes 4-7 are 0 and all other bytes are 0xFF.
- WRAP: AW addr=0x130, len=3, size=4, burst=2'b10. The beats land at 0x130, 0x100, 0x110, 0x120, which an INCR read from 0x100 confirms.
- Errors:
  - wlast asserted on beat 1 of a len=3 burst -> bresp=2'b10 after beat 3.
  - araddr=0x0010_0000 with DEPTH_LOG2=10 -> rresp=2'b10 and rdata=0 on every beat.
- Backpressure: hold rready=0 for 5 cycles mid-burst. rvalid, rdata and rid stay stable, and no beat is lost or duplicated.
- Reset mid-burst: assert rst_wr at write beat 2. All outputs are 0 on the next clock edge. After release, awready=1 and a fresh burst completes normally.
